// File: rtl/dac8550_rx.sv
// dac8550_rx
//   Receive side of a DAC8550-style 3-wire serial link (sync_n / sclk / din,
//   24-bit frames, MSB first). The link is oversampled on clk, deserialised,
//   and each completed frame is offered as a 16-bit sample plus 2 power-down
//   bits on a valid/ready stream.
//
//   Build option: define DAC_RX_FIFO_EN to place a 2**FIFO_AW entry
//   first-word-fall-through FIFO between frame commit and the output.
//   Without it a single holding register is used and FIFO_AW is ignored.
//
// Ports
//   clk        system clock, at least 4x the link sclk
//   rst        synchronous active-high reset
//   sclk_in    link serial clock (asynchronous)
//   sync_n_in  link frame sync, active-low (asynchronous)
//   din        link serial data (asynchronous)
//   rx_data    received sample
//   rx_pd      received power-down bits
//   rx_valid   rx_data/rx_pd hold a word
//   rx_ready   downstream accepts the word when rx_valid & rx_ready
//   frame_err  one-clk pulse: sync_n rose before a full frame
//   overflow   sticky: a frame completed with no free storage
module dac8550_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_in,
  input  logic        sync_n_in,
  input  logic        din,
  output logic [15:0] rx_data,
  output logic [1:0]  rx_pd,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overflow
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  // Only the low 18 bits carry information; the ignored top bits of the
  // frame simply shift out of the register.
  localparam int WORD_W = 18;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  // Stage p0: input synchronisers and sclk edge detect
  logic [SYNC_STAGES-1:0] sclk_p0, sync_p0, din_p0;
  logic                   sclk_d_p0;
  logic                   sclk_s, sync_s, din_s, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0   <= '0;
      sync_p0   <= '1;
      din_p0    <= '0;
      sclk_d_p0 <= 1'b0;
    end else begin
      sclk_p0   <= {sclk_p0[SYNC_STAGES-2:0], sclk_in};
      sync_p0   <= {sync_p0[SYNC_STAGES-2:0], sync_n_in};
      din_p0    <= {din_p0[SYNC_STAGES-2:0], din};
      sclk_d_p0 <= sclk_s;
    end
  end

  assign sclk_s = sclk_p0[SYNC_STAGES-1];
  assign sync_s = sync_p0[SYNC_STAGES-1];
  assign din_s  = din_p0[SYNC_STAGES-1];
  assign fall   = sclk_d_p0 & ~sclk_s;

  // Stage p1: frame FSM and shift register
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              vld_p1;
  logic              shift_en;

  // A fall in the same cycle that sync_n is first seen low is the MSB.
  assign shift_en = fall & ((state == SHIFT) | ((state == IDLE) & ~sync_s));

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {shreg[WORD_W-2:0], din_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync_s) begin
            state   <= SHIFT;
            bit_cnt <= fall ? CNT_W'(1) : '0;
          end
        end
        SHIFT: begin
          // A fall completing the frame wins over a coincident sync_n rise.
          if (fall) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              vld_p1 <= 1'b1;
              state  <= WAIT;
            end
          end else if (sync_s) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        WAIT: begin
          // Further sclk activity in this sync_n-low window is ignored.
          if (sync_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p2: output storage
  logic pop;
  assign pop = rx_valid & rx_ready;

`ifdef DAC_RX_FIFO_EN
  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, push;

  assign full = (count == (FIFO_AW + 1)'(DEPTH));
  // A pop frees the head this cycle, so a full FIFO can still accept.
  assign push = vld_p1 & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      if (vld_p1 & full & ~pop) overflow <= 1'b1;
    end
  end

  // First-word-fall-through head; outputs read as zero while empty.
  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr][15:0]  : '0;
  assign rx_pd    = rx_valid ? mem[rd_ptr][17:16] : '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_pd    <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (vld_p1) begin
        // Commit with a simultaneous pop replaces the word without a bubble.
        if (!rx_valid || pop) begin
          rx_data  <= shreg[15:0];
          rx_pd    <= shreg[17:16];
          rx_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dac8550_rx.sv
// tb_dac8550_rx
//   Self-checking bench for dac8550_rx: a table of directed frames, hand
//   sequences for frame error, overflow and mid-frame reset, and 100 random
//   back-to-back frames compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_dac8550_rx;

  localparam int SYNC_STAGES = 2;
  // Drive of the last sclk fall to first visible rx_valid, in clk cycles:
  // synchroniser stages, edge detect, commit, output register.
  localparam int LAT = SYNC_STAGES + 3;
`ifdef DAC_RX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_in = 1'b0;
  logic        sync_n_in = 1'b1;
  logic        din = 1'b0;
  logic        rx_ready = 1'b1;
  logic [15:0] rx_data;
  logic [1:0]  rx_pd;
  logic        rx_valid, frame_err, overflow;

  dac8550_rx #(.FRAME_BITS(24), .SYNC_STAGES(SYNC_STAGES), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .sync_n_in (sync_n_in),
    .din       (din),
    .rx_data   (rx_data),
    .rx_pd     (rx_pd),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] w;
    bit          sim;
    int          half;
    logic [15:0] ed;
    logic [1:0]  ep;
  } vec_t;

  int          nvec = 0, nerr = 0;
  int          cyc = 0, err_cnt = 0, vld_cycles = 0, pop_cyc = 0, fall_cyc = 0;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [17:0] pw = '0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output monitor: collects popped words and checks hold-while-stalled.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (pv && !pr) check("hold", {13'd0, rx_valid, rx_pd, rx_data}, {13'd0, 1'b1, pw});
      if (rx_valid) vld_cycles++;
      if (rx_valid && rx_ready) begin
        got.push_back({rx_pd, rx_data});
        pop_cyc = cyc;
      end
      if (frame_err) err_cnt++;
    end
    pv = rx_valid && !rst;
    pr = rx_ready;
    pw = {rx_pd, rx_data};
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      rx_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Transmitter: drives on sclk rise, receiver samples on fall.
  task automatic send_frame(input logic [23:0] w, input int half, input int nbits, input bit sim);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b1;
      din     = w[23-i];
      if (!(sim && i == 0)) sync_n_in = 1'b0;
      tick(half);
      sclk_in   = 1'b0;
      sync_n_in = 1'b0;
      fall_cyc  = cyc;
      tick(half);
    end
    sync_n_in = 1'b1;
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 3000) begin
      tick(1);
      k++;
    end
    if (got.size() < n) begin
      nvec++;
      nerr++;
      $display("FAIL %s: timeout, %0d words seen, %0d required", name, got.size(), n);
    end
  endtask

  task automatic take(input string name, input logic [17:0] req);
    if (got.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: no word, expected %0h", name, req);
    end else begin
      check(name, {14'd0, got.pop_front()}, {14'd0, req});
    end
  endtask

  initial begin
    vec_t        tbl[5];
    logic [23:0] w;
    logic [17:0] e4[$];

    tbl[0] = '{24'h001234, 1'b0, 4, 16'h1234, 2'd0};
    tbl[1] = '{24'h03ABCD, 1'b0, 4, 16'hABCD, 2'd3};
    tbl[2] = '{24'hFFABCD, 1'b0, 4, 16'hABCD, 2'd3};
    tbl[3] = '{24'h81C3E5, 1'b1, 4, 16'hC3E5, 2'd1};
    tbl[4] = '{24'h028001, 1'b0, 2, 16'h8001, 2'd2};

    rst = 1'b1;
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_pd", rx_pd, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick(4);

    // Directed frames, including the sync_n/sclk-fall coincidence case.
    for (int i = 0; i < 5; i++) begin
      vld_cycles = 0;
      send_frame(tbl[i].w, tbl[i].half, 24, tbl[i].sim);
      tick(2 * tbl[i].half);
      wait_got(1, $sformatf("vec%0d_wait", i));
      if (i == 0) begin
        check("t1_latency", pop_cyc - fall_cyc, LAT);
        check("t1_pulse", vld_cycles, 1);
      end
      take($sformatf("vec%0d_word", i), {tbl[i].ep, tbl[i].ed});
    end

    // Truncated frame, then a good frame.
    send_frame(24'h00FFFF, 4, 10, 1'b0);
    tick(16);
    check("t3_frame_err", err_cnt, 1);
    check("t3_no_word", got.size(), 0);
    send_frame(24'h005A5A, 4, 24, 1'b0);
    tick(8);
    wait_got(1, "t3_wait");
    take("t3_next", 18'h05A5A);

    // Stalled output, two frames.
    rx_ready = 1'b0;
    send_frame(24'h001111, 4, 24, 1'b0);
    tick(8);
    send_frame(24'h002222, 4, 24, 1'b0);
    tick(8);
    check("t4_valid", rx_valid, 1);
    check("t4_head", rx_data, 16'h1111);
    check("t4_overflow", overflow, FIFO ? 0 : 1);
    e4.push_back(18'h01111);
    if (FIFO) e4.push_back(18'h02222);
    rx_ready = 1'b1;
    wait_got(e4.size(), "t4_wait");
    tick(4);
    check("t4_count", got.size(), e4.size());
    foreach (e4[i]) take($sformatf("t4_word%0d", i), e4[i]);

    // Reset in the middle of a frame.
    sync_n_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sclk_in = 1'b1;
      din     = i[0];
      tick(4);
      sclk_in = 1'b0;
      tick(4);
    end
    rst = 1'b1;
    tick(1);
    check("t5_valid", rx_valid, 0);
    check("t5_data", rx_data, 0);
    check("t5_pd", rx_pd, 0);
    check("t5_frame_err", frame_err, 0);
    check("t5_overflow", overflow, 0);
    sync_n_in = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("t5_no_word", got.size(), 0);
    send_frame(24'h007FFF, 4, 24, 1'b0);
    tick(8);
    wait_got(1, "t5_wait");
    take("t5_next", 18'h07FFF);

    // Random back-to-back frames at sclk = clk/4, sync_n high one sclk period.
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = 24'($urandom);
      exp_q.push_back(18'(w & 24'h03FFFF));
      send_frame(w, 2, 24, 1'b0);
      tick(4);
    end
    rand_ready = 1'b0;
    tick(1);
    rx_ready = 1'b1;
    tick(20);
    wait_got(100, "t6_wait");
    foreach (exp_q[i]) take($sformatf("t6_word%0d", i), exp_q[i]);
    check("t6_overflow", overflow, 0);
    check("t6_frame_err_total", err_cnt, 1);
    check("t6_leftover", got.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
